// File: rtl/sbox_lane_array.sv
// Multi-lane AES SubBytes / InvSubBytes unit with an elastic valid/ready pipe.
// Optional per-lane output parity is enabled by defining SBOX_PARITY_EN.
module sbox_lane_array #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [8*LANES-1:0]   out_data,
`ifdef SBOX_PARITY_EN
    output logic [LANES-1:0]     out_parity,
`endif
    output logic                 busy
);

    localparam int DW   = 8 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    generate
        if (LANES < 1 || LANES > 16 || PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_param
            $fatal(1, "sbox_lane_array: LANES must be 1..16 and PIPE_STAGES 1..3");
        end
    endgenerate

    // FIPS-197 forward S-box; entry 0 sits in the most significant byte.
    localparam logic [2047:0] FWD_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse table derived at elaboration; entry 0 sits in the least significant byte.
    function automatic logic [2047:0] f_build_inv(input logic [2047:0] fwd);
        logic [2047:0] inv;
        logic [7:0]    s;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            s = fwd[2047-8*i -: 8];
            inv[8*int'(s) +: 8] = 8'(i);
        end
        return inv;
    endfunction

    localparam logic [2047:0] INV_FLAT = f_build_inv(FWD_FLAT);

`ifdef SBOX_PARITY_EN
    function automatic logic [255:0] f_build_par(input logic [2047:0] tbl, input bit msb_first);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 256; i++) begin
            p[i] = msb_first ? ^tbl[2047-8*i -: 8] : ^tbl[8*i +: 8];
        end
        return p;
    endfunction

    localparam logic [255:0] PAR_FWD = f_build_par(FWD_FLAT, 1'b1);
    localparam logic [255:0] PAR_INV = f_build_par(INV_FLAT, 1'b0);

    logic [LANES-1:0] w_par;
    logic [LANES-1:0] r_par [PIPE_STAGES];
`endif

    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_mode;
    logic [DW-1:0]          r_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_adv;
    logic [DW-1:0]          w_sub;
    logic                   w_accept;

    // A stage advances when it, or any stage downstream of it, is empty, or the sink accepts.
    always_comb begin
        logic v_full;
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        w_adv  = '0;
        v_full = 1'b1;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            v_full = 1'b1;
            for (int j = k; j < PIPE_STAGES; j++) begin
                v_full = v_full & r_valid[j];
            end
            w_adv[k] = out_ready | ~v_full;
        end
    end

    assign in_ready = w_adv[0];
    assign w_accept = in_valid & in_ready;

    always_comb begin
        logic [7:0] lane_b;
        lane_b = '0;
        w_sub  = '0;
`ifdef SBOX_PARITY_EN
        w_par  = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_b = in_data[8*i +: 8];
            if (in_mode) begin
                w_sub[8*i +: 8] = INV_FLAT[8*int'(lane_b) +: 8];
            end else begin
                w_sub[8*i +: 8] = FWD_FLAT[2047-8*int'(lane_b) -: 8];
            end
`ifdef SBOX_PARITY_EN
            w_par[i] = in_mode ? PAR_INV[lane_b] : PAR_FWD[lane_b];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mode  <= '0;
            // NOTE: data registers are reset too, because the output word must read zero out of reset.
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_data[k] <= '0;
`ifdef SBOX_PARITY_EN
                r_par[k]  <= '0;
`endif
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            if (w_adv[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_sub;
                    r_mode[0] <= in_mode;
`ifdef SBOX_PARITY_EN
                    r_par[0]  <= w_par;
`endif
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_mode[k] <= r_mode[k-1];
`ifdef SBOX_PARITY_EN
                        r_par[k]  <= r_par[k-1];
`endif
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_mode  = r_mode[LAST];
    assign out_data  = r_data[LAST];
    assign busy      = |r_valid;
`ifdef SBOX_PARITY_EN
    assign out_parity = r_par[LAST];
`endif

endmodule

// File: tb/tb_sbox_lane_array.sv
// Scoreboard bench for sbox_lane_array; the reference S-box is computed from GF(2^8) arithmetic.
// Define SBOX_PARITY_EN to also check the per-lane parity output.
module tb_sbox_lane_array;

    localparam int LANES = 16;
    localparam int PIPE  = 2;
    localparam int DW    = 8 * LANES;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_mode   = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_mode;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef SBOX_PARITY_EN
    logic [LANES-1:0] out_parity;
`endif

    sbox_lane_array #(.LANES(LANES), .PIPE_STAGES(PIPE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
`ifdef SBOX_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: multiplicative inverse in GF(2^8) followed by the affine map.
    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        if (x == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [DW-1:0] model(input logic mode, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[8*i +: 8] = mode ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] lane_par(input logic [DW-1:0] d);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    typedef struct {
        logic          mode;
        logic [DW-1:0] data;
        int            acc_cyc;
        bit            chk_lat;
        bit            loopback;
    } exp_t;

    exp_t          sb_q   [$];
    logic [DW-1:0] loop_q [$];

    // 0: sink always ready, 1: sink stalled, 2: random ready.
    int rdy_mode = 0;
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    exp_t          mon_e;
    bit            hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_m;
`ifdef SBOX_PARITY_EN
    logic [LANES-1:0] hold_p;
`endif

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_data", 128'(out_data), 128'(hold_d));
                check("hold_mode", 128'(out_mode), 128'(hold_m));
`ifdef SBOX_PARITY_EN
                check("hold_parity", 128'(out_parity), 128'(hold_p));
`endif
            end
`ifdef SBOX_PARITY_EN
            if (out_valid) check("parity", 128'(out_parity), 128'(lane_par(out_data)));
`endif
            if (out_valid && out_ready) begin
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("out_data", 128'(out_data), 128'(mon_e.data));
                    check("out_mode", 128'(out_mode), 128'(mon_e.mode));
                    if (mon_e.chk_lat) check("latency", 128'(cyc - mon_e.acc_cyc), 128'(PIPE));
                    if (mon_e.loopback) loop_q.push_back(out_data);
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
                hold_m = out_mode;
`ifdef SBOX_PARITY_EN
                hold_p = out_parity;
`endif
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic set_rdy(input int m);
        rdy_mode = m;
        @(negedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic try_send(input logic mode, input logic [DW-1:0] d, input logic [DW-1:0] exp,
                            input bit lb, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        #1;
        acc = in_ready;
        if (acc) begin
            e.mode     = mode;
            e.data     = exp;
            e.acc_cyc  = cyc;
            e.chk_lat  = (rdy_mode == 0);
            e.loopback = lb;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic mode, input logic [DW-1:0] d, input logic [DW-1:0] exp, input bit lb);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) try_send(mode, d, exp, lb, acc);
        if (!acc) check("send_accept", 128'(acc), 128'(1));
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            #2;
            done = (sb_q.size() == 0) && !busy;
        end
        check("drain", 128'(done), 128'(1));
    endtask

    task automatic wait_loop(output logic [DW-1:0] fb, output bit ok);
        for (int i = 0; i < 200 && loop_q.size() == 0; i++) begin
            @(negedge clk);
            #2;
        end
        ok = (loop_q.size() != 0);
        check("loop_wait", 128'(ok), 128'(1));
        fb = ok ? loop_q.pop_front() : '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d, fb;
        logic [7:0]    bp_in [4];
        logic [7:0]    bp_exp [4];
        logic [7:0]    b;
        bit            acc, ok;
        int            idx;

        for (int i = 0; i < 256; i++) begin
            b = ginv(8'(i));
            m_fwd[i] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) m_inv[m_fwd[i]] = 8'(i);

        // Reset and idle
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_data", 128'(out_data), 128'(0));

        // Single forward word
        send(1'b0, {LANES{8'h53}}, {LANES{8'hed}}, 1'b0);
        idle();
        wait_drain();

        // Mixed forward/inverse stream, back to back
        send(1'b0, {LANES{8'h00}}, {LANES{8'h63}}, 1'b0);
        send(1'b1, {LANES{8'h63}}, {LANES{8'h00}}, 1'b0);
        send(1'b1, {LANES{8'hff}}, {LANES{8'h7d}}, 1'b0);
        idle();
        wait_drain();

        // Backpressure: the pipe fills, holds its head word, then drains in order
        bp_in  = '{8'h00, 8'h01, 8'h02, 8'h03};
        bp_exp = '{8'h52, 8'h09, 8'h6a, 8'hd5};
        set_rdy(1);
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            try_send(1'b1, {LANES{bp_in[idx]}}, {LANES{bp_exp[idx]}}, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepts", 128'(idx), 128'(PIPE));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        check("bp_busy", 128'(busy), 128'(1));
        check("bp_hold_data", 128'(out_data), 128'({LANES{8'h52}}));
        rdy_mode = 0;
        for (int k = idx; k < 4; k++) send(1'b1, {LANES{bp_in[k]}}, {LANES{bp_exp[k]}}, 1'b0);
        idle();
        wait_drain();

        // Exhaustive round trip in lane 0 with random sink stalls
        set_rdy(2);
        for (int x = 0; x < 256; x++) begin
            d = rand_word();
            d[7:0] = 8'(x);
            send(1'b0, d, model(1'b0, d), 1'b1);
            idle();
            wait_loop(fb, ok);
            if (ok) send(1'b1, fb, d, 1'b0);
        end
        idle();
        wait_drain();

        // Random mixed stream with input gaps
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) idle();
            d = rand_word();
            b = 8'($urandom_range(0, 1));
            send(b[0], d, model(b[0], d), 1'b0);
        end
        idle();
        wait_drain();

        // Reset while two words are stalled in the pipe
        set_rdy(1);
        send(1'b0, rand_word(), '0, 1'b0);
        send(1'b1, rand_word(), '0, 1'b0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_out_data", 128'(out_data), 128'(0));
        check("mid_rst_out_mode", 128'(out_mode), 128'(0));
`ifdef SBOX_PARITY_EN
        check("mid_rst_parity", 128'(out_parity), 128'(0));
`endif
        sb_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_rdy(0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #2;
            check("post_rst_no_stale", 128'(out_valid), 128'(0));
        end
        check("post_rst_busy", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
